turn_score_controller: RTL and testbench



---
 rtl/hud_pkg.sv | 27 ++
 rtl/sec_tick_gen.sv | 36 +++
 rtl/turn_score_controller.sv | 137 +++++++++++++
 tb/tb_turn_score_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// Shared encodings for the card-match HUD: game states, player codes and winner codes.
package hud_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam logic [1:0] PLAYER_1 = 2'd1;
  localparam logic [1:0] PLAYER_2 = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == PLAYER_1) ? PLAYER_2 : PLAYER_1;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds divider: counts 0..CLK_DIV-1 while enabled and flags the wrap cycle.
// Clear wins over counting, so a cleared cycle never produces a tick.
module sec_tick_gen #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic at_max_o,
  output logic tick_o
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == CNT_MAX);
  assign tick_o   = en_i & ~clr_i & at_max_o;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_max_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/turn_score_controller.sv
// Turn/score controller for the card-match HUD: per-turn countdown, player
// alternation, scoring and winner decision. One event is acted on per cycle.
module turn_score_controller
  import hud_pkg::*;
#(
  parameter int CLK_DIV      = 50000000,
  parameter int TURN_SECONDS = 15,
  parameter int PAIRS        = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic       match,
  input  logic       mismatch,
  input  logic       pause,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] timer,
  output logic [1:0] player,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       tick
);

  localparam logic [3:0] TIMER_RELOAD = 4'(TURN_SECONDS);
  localparam logic [4:0] PAIRS_TOTAL  = 5'(PAIRS);

  state_t     state_q, state_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d, timer_q, timer_d;
  logic [1:0] player_q, player_d, winner_q, winner_d;
  logic       over_q, over_d, tick_q, tick_d;

  logic       in_play, match_evt, mismatch_evt;
  logic       div_en, div_clr, div_at_max, div_tick;
  logic [3:0] p1_new, p2_new;

  assign in_play      = (state_q == ST_PLAY);
  assign match_evt    = in_play & match;
  assign mismatch_evt = in_play & mismatch & ~match;
  assign div_clr      = start | match_evt | mismatch_evt;
  // A pending wrap beats pause entry, so the divider keeps counting into the tick.
  assign div_en       = in_play & (~pause | div_at_max);

  assign p1_new = (player_q == PLAYER_1) ? sat_inc(p1_q) : p1_q;
  assign p2_new = (player_q == PLAYER_2) ? sat_inc(p2_q) : p2_q;

  sec_tick_gen #(.CLK_DIV(CLK_DIV)) u_sec_tick (
    .clk_i    (CLOCK_50),
    .rst_ni   (reset_n),
    .en_i     (div_en),
    .clr_i    (div_clr),
    .at_max_o (div_at_max),
    .tick_o   (div_tick)
  );

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    timer_d  = timer_q;
    player_d = player_q;
    winner_d = winner_q;
    over_d   = over_q;
    tick_d   = 1'b0;
    if (start) begin
      state_d  = ST_PLAY;
      p1_d     = 4'd0;
      p2_d     = 4'd0;
      timer_d  = TIMER_RELOAD;
      player_d = PLAYER_1;
      winner_d = WIN_NONE;
      over_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          if (match_evt) begin
            p1_d    = p1_new;
            p2_d    = p2_new;
            timer_d = TIMER_RELOAD;
            if ({1'b0, p1_new} + {1'b0, p2_new} == PAIRS_TOTAL) begin
              state_d  = ST_OVER;
              over_d   = 1'b1;
              winner_d = (p1_new > p2_new) ? WIN_P1 :
                         (p2_new > p1_new) ? WIN_P2 : WIN_TIE;
            end
          end else if (mismatch_evt) begin
            player_d = other_player(player_q);
            timer_d  = TIMER_RELOAD;
          end else if (div_tick) begin
            tick_d = 1'b1;
            if (timer_q == 4'd0) begin
              player_d = other_player(player_q);
              timer_d  = TIMER_RELOAD;
            end else begin
              timer_d = timer_q - 4'd1;
            end
          end else if (pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: if (!pause) state_d = ST_PLAY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      p1_q     <= 4'd0;
      p2_q     <= 4'd0;
      timer_q  <= TIMER_RELOAD;
      player_q <= PLAYER_1;
      winner_q <= WIN_NONE;
      over_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      timer_q  <= timer_d;
      player_q <= player_d;
      winner_q <= winner_d;
      over_q   <= over_d;
      tick_q   <= tick_d;
    end
  end

  assign p1_score  = p1_q;
  assign p2_score  = p2_q;
  assign timer     = timer_q;
  assign player    = player_q;
  assign winner    = winner_q;
  assign game_over = over_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_turn_score_controller.sv
// Bench for turn_score_controller: directed test-plan walk plus random play,
// all checked cycle by cycle against a rule-level game model.
module tb_turn_score_controller;

  localparam int CLK_DIV = 4;
  localparam int TURN    = 3;
  localparam int PAIRS   = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       start = 1'b0, match = 1'b0, mismatch = 1'b0, pause = 1'b0;
  logic [3:0] p1_score, p2_score, timer;
  logic [1:0] player, winner;
  logic       game_over, tick;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 idle, 1 playing, 2 paused, 3 over; sec = cycles into current second.
  int m_mode, m_sec, m_p1, m_p2, m_timer, m_player, m_winner, m_over, m_tick;

  turn_score_controller #(.CLK_DIV(CLK_DIV), .TURN_SECONDS(TURN), .PAIRS(PAIRS)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .start     (start),
    .match     (match),
    .mismatch  (mismatch),
    .pause     (pause),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .timer     (timer),
    .player    (player),
    .winner    (winner),
    .game_over (game_over),
    .tick      (tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sec = 0; m_p1 = 0; m_p2 = 0; m_timer = TURN;
    m_player = 1; m_winner = 0; m_over = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit s, input bit m, input bit mm, input bit p);
    m_tick = 0;
    if (s) begin
      m_mode = 1; m_sec = 0; m_p1 = 0; m_p2 = 0; m_timer = TURN;
      m_player = 1; m_winner = 0; m_over = 0;
    end else if (m_mode == 1) begin
      if (m) begin
        if (m_player == 1) m_p1 = (m_p1 < 15) ? m_p1 + 1 : 15;
        else               m_p2 = (m_p2 < 15) ? m_p2 + 1 : 15;
        m_timer = TURN; m_sec = 0;
        if (m_p1 + m_p2 == PAIRS) begin
          m_mode = 3; m_over = 1;
          m_winner = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 3;
        end
      end else if (mm) begin
        m_player = 3 - m_player; m_timer = TURN; m_sec = 0;
      end else if (m_sec == CLK_DIV - 1) begin
        m_sec = 0; m_tick = 1;
        if (m_timer == 0) begin
          m_player = 3 - m_player; m_timer = TURN;
        end else begin
          m_timer--;
        end
      end else if (p) begin
        m_mode = 2;
      end else begin
        m_sec++;
      end
    end else if (m_mode == 2) begin
      if (!p) m_mode = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".p1"},     int'(p1_score),  m_p1);
    chk({tag, ".p2"},     int'(p2_score),  m_p2);
    chk({tag, ".timer"},  int'(timer),     m_timer);
    chk({tag, ".player"}, int'(player),    m_player);
    chk({tag, ".winner"}, int'(winner),    m_winner);
    chk({tag, ".over"},   int'(game_over), m_over);
    chk({tag, ".tick"},   int'(tick),      m_tick);
  endtask

  // Called at a negedge: drive, clock, advance the model, compare at the next negedge.
  task automatic run_cycle(input string tag, input bit s, input bit m, input bit mm, input bit p);
    start = s; match = m; mismatch = mm; pause = p;
    @(posedge CLOCK_50);
    model_step(s, m, mm, p);
    @(negedge CLOCK_50);
    check_all(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n, input bit p);
    for (int i = 0; i < n; i++) run_cycle(tag, 1'b0, 1'b0, 1'b0, p);
  endtask

  task automatic async_reset(input string tag);
    start = 0; match = 0; mismatch = 0; pause = 0;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all({tag, ".async"});
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    check_all({tag, ".held"});
  endtask

  initial begin
    bit s, m, mm, p;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    check_all("reset");
    reset_n = 1'b1;
    idle_cycles("idle_ignore", 1, 1'b0);
    run_cycle("idle_ignore", 1'b0, 1'b1, 1'b1, 1'b1);
    $display("reset: player=%0d timer=%0d", player, timer);

    run_cycle("start", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("start.player", int'(player), 1);
    chk("start.timer", int'(timer), TURN);
    idle_cycles("countdown", 16, 1'b0);
    chk("timeout.player", int'(player), 2);
    chk("timeout.timer", int'(timer), TURN);
    $display("countdown: timeout -> player=%0d timer=%0d", player, timer);

    run_cycle("match_mis_p2", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("match_mis.p2", int'(p2_score), 1);
    chk("match_mis.player", int'(player), 2);
    run_cycle("mismatch", 1'b0, 1'b0, 1'b1, 1'b0);
    $display("match+mismatch: p2=%0d player=%0d", p2_score, player);

    run_cycle("restart", 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles("to_timeout", 15, 1'b0);
    run_cycle("match_on_timeout", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("match_on_timeout.player", int'(player), 1);
    chk("match_on_timeout.p1", int'(p1_score), 1);
    idle_cycles("after_match", 4, 1'b0);
    run_cycle("p1_miss", 1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle("p2_match", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("over.winner", int'(winner), 3);
    chk("over.flag", int'(game_over), 1);
    run_cycle("over_hold", 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles("over_hold", 8, 1'b0);
    run_cycle("over_restart", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart.winner", int'(winner), 0);
    $display("game over: tie declared, restart winner=%0d", winner);

    idle_cycles("pre_pause", 6, 1'b0);
    idle_cycles("paused", 10, 1'b1);
    run_cycle("paused_match", 1'b0, 1'b1, 1'b0, 1'b1);
    idle_cycles("paused", 9, 1'b1);
    chk("pause.timer", int'(timer), 2);
    idle_cycles("resume", 6, 1'b0);
    $display("pause: resumed timer=%0d", timer);

    idle_cycles("pre_reset", 3, 1'b0);
    async_reset("midplay");
    idle_cycles("after_reset", 6, 1'b0);
    $display("async reset: timer=%0d player=%0d", timer, player);

    p = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rand");
        p = 0;
      end
      s  = ($urandom_range(0, 39) == 0);
      m  = ($urandom_range(0, 7) == 0);
      mm = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 11) == 0) p = ~p;
      run_cycle("rand", s, m, mm, p);
      if (i % 1000 == 999)
        $display("random burst %0d: p1=%0d p2=%0d winner=%0d", i / 1000, p1_score, p2_score, winner);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
